// File: rtl/spi_regbank_pkg.sv
// Shared types and constants for the SPI register bank.
// Holds the frame FSM states and the command-byte layout.
package spi_regbank_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } spi_state_t;

    localparam int CMD_WIDTH = 8;
    localparam int RW_BIT    = 7;

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the clk domain and decodes
// sample/shift edges for the frame's latched {CPOL,CPHA}.
module spi_pin_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpol_rst,
    input  logic [1:0] mode_lat,
    input  logic       spi_cs_n,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    output logic       mosi_s,
    output logic       sample_edge,
    output logic       shift_edge,
    output logic       cs_fall,
    output logic       cs_rise
);

    logic [1:0] cs_sync_reg;
    logic [1:0] sclk_sync_reg;
    logic [1:0] mosi_sync_reg;
    logic       cs_prev_reg;
    logic       sclk_prev_reg;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       lead_edge;
    logic       trail_edge;

    // The clock synchroniser starts at the idle level so reset release
    // does not fake an SPI edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_reg   <= 2'b11;
            sclk_sync_reg <= {2{cpol_rst}};
            mosi_sync_reg <= 2'b00;
            cs_prev_reg   <= 1'b1;
            sclk_prev_reg <= cpol_rst;
        end else begin
            cs_sync_reg   <= {cs_sync_reg[0], spi_cs_n};
            sclk_sync_reg <= {sclk_sync_reg[0], spi_clk};
            mosi_sync_reg <= {mosi_sync_reg[0], spi_mosi};
            cs_prev_reg   <= cs_sync_reg[1];
            sclk_prev_reg <= sclk_sync_reg[1];
        end
    end

    assign sclk_rise   = sclk_sync_reg[1] & ~sclk_prev_reg;
    assign sclk_fall   = ~sclk_sync_reg[1] & sclk_prev_reg;
    assign lead_edge   = mode_lat[1] ? sclk_fall : sclk_rise;
    assign trail_edge  = mode_lat[1] ? sclk_rise : sclk_fall;
    assign sample_edge = mode_lat[0] ? trail_edge : lead_edge;
    assign shift_edge  = mode_lat[0] ? lead_edge : trail_edge;
    assign cs_fall     = ~cs_sync_reg[1] & cs_prev_reg;
    assign cs_rise     = cs_sync_reg[1] & ~cs_prev_reg;
    assign mosi_s      = mosi_sync_reg[1];

endmodule

// File: rtl/spi_regbank.sv
// SPI-slave register bank: read/write config registers followed by
// read-only status registers, with burst auto-increment and status snapshots.
module spi_regbank
    import spi_regbank_pkg::*;
#(
    parameter int                           NUM_CFG     = 8,
    parameter int                           NUM_STATUS  = 8,
    parameter int                           REG_WIDTH   = 8,
    parameter logic [NUM_CFG*REG_WIDTH-1:0] CFG_RST_VAL = '0,
    localparam int                          NUM_REGS    = NUM_CFG + NUM_STATUS,
    localparam int                          ADDR_WIDTH  = $clog2(NUM_REGS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ena,
    input  logic [1:0]                      mode,
    input  logic                            spi_cs_n,
    input  logic                            spi_clk,
    input  logic                            spi_mosi,
    output logic                            spi_miso,
    input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
    output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
    output logic                            cfg_wr_stb,
    output logic [ADDR_WIDTH-1:0]           cfg_wr_addr
);

    localparam int SW    = (REG_WIDTH > CMD_WIDTH) ? REG_WIDTH : CMD_WIDTH;
    localparam int CNT_W = $clog2(SW);
    localparam logic [CNT_W-1:0]      LAST_CMD_BIT = CNT_W'(CMD_WIDTH - 1);
    localparam logic [CNT_W-1:0]      LAST_DAT_BIT = CNT_W'(REG_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR    = ADDR_WIDTH'(NUM_REGS - 1);

    generate
        if (ADDR_WIDTH > 7) begin : g_addr_chk
            $error("spi_regbank: NUM_CFG+NUM_STATUS needs more than 7 address bits");
        end
    endgenerate

    spi_state_t             state_reg, state_next;
    logic [1:0]             mode_reg, mode_next;
    logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
    logic [SW-2:0]          shift_in_reg, shift_in_next;
    logic [REG_WIDTH-1:0]   shift_out_reg, shift_out_next;
    logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
    logic                   rw_reg, rw_next;
    logic                   miso_reg, miso_next;
    logic                   wr_stb_reg, wr_stb_next;
    logic [ADDR_WIDTH-1:0]  wr_addr_reg, wr_addr_next;
    logic [REG_WIDTH-1:0]   cfg_mem [NUM_CFG];

    logic                   mosi_s, sample_edge, shift_edge, cs_fall, cs_rise;
    logic [SW-1:0]          shift_word;
    logic [ADDR_WIDTH-1:0]  addr_inc, rd_addr;
    logic [REG_WIDTH-1:0]   rd_word;
    logic                   cfg_we;
    logic                   addr_is_cfg;

    spi_pin_sync u_pin_sync (
        .clk         (clk),
        .rst         (rst),
        .cpol_rst    (mode[1]),
        .mode_lat    (mode_reg),
        .spi_cs_n    (spi_cs_n),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .mosi_s      (mosi_s),
        .sample_edge (sample_edge),
        .shift_edge  (shift_edge),
        .cs_fall     (cs_fall),
        .cs_rise     (cs_rise)
    );

    assign shift_word  = {shift_in_reg, mosi_s};
    assign addr_inc    = (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;
    assign rd_addr     = (state_reg == CMD) ? shift_word[ADDR_WIDTH-1:0] : addr_inc;
    assign addr_is_cfg = {1'b0, addr_reg} < (ADDR_WIDTH + 1)'(NUM_CFG);

    // Read mux; status words are copied into the shift-out register on
    // the load cycle, which gives the snapshot behaviour for free.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) rd_word = cfg_mem[i];
        end
        for (int j = 0; j < NUM_STATUS; j++) begin
            if (rd_addr == ADDR_WIDTH'(NUM_CFG + j)) rd_word = status_regs[j*REG_WIDTH +: REG_WIDTH];
        end
    end

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_in_next  = shift_in_reg;
        shift_out_next = shift_out_reg;
        addr_next      = addr_reg;
        rw_next        = rw_reg;
        miso_next      = miso_reg;
        wr_stb_next    = 1'b0;
        wr_addr_next   = wr_addr_reg;
        cfg_we         = 1'b0;

        if (!ena) begin
            state_next = IDLE;
            miso_next  = 1'b0;
            if (state_reg == IDLE) mode_next = mode;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    miso_next = 1'b0;
                    mode_next = mode;
                    if (cs_fall) begin
                        state_next   = CMD;
                        bit_cnt_next = '0;
                    end
                end
                CMD: begin
                    if (sample_edge) begin
                        shift_in_next = shift_word[SW-2:0];
                        if (bit_cnt_reg == LAST_CMD_BIT) begin
                            state_next     = DATA;
                            bit_cnt_next   = '0;
                            rw_next        = shift_word[RW_BIT];
                            addr_next      = shift_word[ADDR_WIDTH-1:0];
                            shift_out_next = rd_word;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (shift_edge && !rw_reg) begin
                        miso_next      = shift_out_reg[REG_WIDTH-1];
                        shift_out_next = shift_out_reg << 1;
                    end
                    if (sample_edge) begin
                        shift_in_next = shift_word[SW-2:0];
                        if (bit_cnt_reg == LAST_DAT_BIT) begin
                            bit_cnt_next = '0;
                            addr_next    = addr_inc;
                            if (rw_reg) begin
                                if (addr_is_cfg) begin
                                    cfg_we       = 1'b1;
                                    wr_stb_next  = 1'b1;
                                    wr_addr_next = addr_reg;
                                end
                            end else begin
                                shift_out_next = rd_word;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
            // Applied after the sample handling so a final bit coinciding
            // with cs_n rising still commits.
            if (cs_rise && state_reg != IDLE) begin
                state_next = IDLE;
                miso_next  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            mode_reg      <= 2'b00;
            bit_cnt_reg   <= '0;
            shift_in_reg  <= '0;
            shift_out_reg <= '0;
            addr_reg      <= '0;
            rw_reg        <= 1'b0;
            miso_reg      <= 1'b0;
            wr_stb_reg    <= 1'b0;
            wr_addr_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_in_reg  <= shift_in_next;
            shift_out_reg <= shift_out_next;
            addr_reg      <= addr_next;
            rw_reg        <= rw_next;
            miso_reg      <= miso_next;
            wr_stb_reg    <= wr_stb_next;
            wr_addr_reg   <= wr_addr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                cfg_mem[i] <= CFG_RST_VAL[i*REG_WIDTH +: REG_WIDTH];
            end
        end else begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (cfg_we && addr_reg == ADDR_WIDTH'(i)) cfg_mem[i] <= shift_word[REG_WIDTH-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CFG; gi++) begin : g_cfg_out
            assign config_regs[gi*REG_WIDTH +: REG_WIDTH] = cfg_mem[gi];
        end
    endgenerate

    assign spi_miso    = miso_reg;
    assign cfg_wr_stb  = wr_stb_reg;
    assign cfg_wr_addr = wr_addr_reg;

endmodule

// File: tb/tb_spi_regbank.sv
// Directed bench for spi_regbank: an SPI master drives frames, expected
// strobes and read words go into queues that separate monitors drain.
module tb_spi_regbank;

    localparam logic [63:0] RST_IMG = 64'h0706050403020100;
    localparam int HP = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        spi_cs_n = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [63:0] status_regs = 64'h0;
    logic [63:0] config_regs;
    logic        cfg_wr_stb;
    logic [3:0]  cfg_wr_addr;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    logic [7:0]  got_rd [$];
    logic [11:0] wr_e;
    logic [7:0]  rd_exp, rd_got;
    logic [7:0]  scratch;
    event        rd_done;

    always #5 clk = ~clk;

    spi_regbank #(
        .NUM_CFG     (8),
        .NUM_STATUS  (8),
        .REG_WIDTH   (8),
        .CFG_RST_VAL (RST_IMG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .mode        (mode),
        .spi_cs_n    (spi_cs_n),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .status_regs (status_regs),
        .config_regs (config_regs),
        .cfg_wr_stb  (cfg_wr_stb),
        .cfg_wr_addr (cfg_wr_addr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Write-strobe monitor: every strobe must match the next queued write.
    always @(negedge clk) begin
        if (!rst && cfg_wr_stb === 1'b1) begin
            if (exp_wr.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: got strobe at addr %0d, expected none", cfg_wr_addr);
            end else begin
                wr_e = exp_wr.pop_front();
                check("strobe_addr", 64'(cfg_wr_addr), 64'(wr_e[11:8]));
                check("strobe_data", 64'(config_regs[wr_e[10:8]*8 +: 8]), 64'(wr_e[7:0]));
            end
        end
    end

    // Read monitor: pairs each received word with the queued expectation.
    initial begin
        forever begin
            @(rd_done);
            while (got_rd.size() > 0 && exp_rd.size() > 0) begin
                rd_got = got_rd.pop_front();
                rd_exp = exp_rd.pop_front();
                check("spi_read", 64'(rd_got), 64'(rd_exp));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!mode[0]) begin
                spi_mosi = tx[7-i];
                #HP;
                spi_clk = ~mode[1];
                rx = {rx[6:0], spi_miso};
                #HP;
                spi_clk = mode[1];
            end else begin
                spi_clk  = ~mode[1];
                spi_mosi = tx[7-i];
                #HP;
                spi_clk = mode[1];
                rx = {rx[6:0], spi_miso};
                #HP;
            end
        end
    endtask

    task automatic cs_low(input logic [1:0] m);
        mode    = m;
        spi_clk = m[1];
        #(4*HP);
        spi_cs_n = 1'b0;
        #HP;
    endtask

    task automatic cs_high();
        #HP;
        spi_cs_n = 1'b1;
        #(2*HP);
    endtask

    task automatic write_frame(input logic [1:0] m, input logic [7:0] cmd, input logic [23:0] data, input int nw);
        logic [7:0] rx;
        logic [7:0] miso_or;
        miso_or = '0;
        cs_low(m);
        xfer(cmd, 8, rx);
        miso_or |= rx;
        for (int k = 0; k < nw; k++) begin
            xfer(data[23-8*k -: 8], 8, rx);
            miso_or |= rx;
        end
        cs_high();
        check("write_miso_low", 64'(miso_or), 64'h0);
        $display("write mode=%0d cmd=%h words=%0d data=%h", m, cmd, nw, data);
    endtask

    task automatic read_frame(input logic [1:0] m, input logic [7:0] cmd, input logic [7:0] exp, input bit glitch);
        logic [7:0] hi, lo, saved;
        exp_rd.push_back(exp);
        cs_low(m);
        xfer(cmd, 8, hi);
        xfer(8'h00, 4, hi);
        saved = status_regs[7:0];
        if (glitch) status_regs[7:0] = ~saved;
        xfer(8'h00, 4, lo);
        status_regs[7:0] = saved;
        cs_high();
        got_rd.push_back({hi[3:0], lo[3:0]});
        -> rd_done;
        $display("read  mode=%0d cmd=%h got=%h expect=%h glitch=%0d", m, cmd, {hi[3:0], lo[3:0]}, exp, glitch);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_config", config_regs, RST_IMG);
        check("rst_miso", 64'(spi_miso), 64'h0);
        check("rst_stb", 64'(cfg_wr_stb), 64'h0);
        check("rst_wr_addr", 64'(cfg_wr_addr), 64'h0);
        rst = 1'b0;
        ena = 1'b1;
        #(4*HP);
        $display("reset released");

        // Single mode-0 write
        exp_wr.push_back({4'd3, 8'hA5});
        write_frame(2'd0, 8'h83, 24'hA50000, 1);
        check("single_write_image", config_regs, 64'h07060504_A5020100);

        // Status read with mid-word change, all modes; plus config/status reads
        status_regs[7:0]  = 8'hCA;
        status_regs[15:8] = 8'h5E;
        for (int m = 0; m < 4; m++) read_frame(2'(m), 8'h08, 8'hCA, 1'b1);
        read_frame(2'd0, 8'h03, 8'hA5, 1'b0);
        read_frame(2'd3, 8'h09, 8'h5E, 1'b0);

        // Burst across status regs with wrap-around
        exp_wr.push_back({4'd0, 8'h33});
        write_frame(2'd0, 8'h8E, 24'h112233, 3);
        check("burst_image", config_regs, 64'h07060504_A5020133);

        // Partial word then full frame
        cs_low(2'd1);
        xfer(8'h82, 8, scratch);
        check("partial_cmd_miso", 64'(scratch), 64'h0);
        xfer(8'hFF, 5, scratch);
        check("partial_data_miso", 64'(scratch), 64'h0);
        cs_high();
        $display("write mode=1 cmd=82 partial 5 bits");
        check("partial_image", config_regs, 64'h07060504_A5020133);
        exp_wr.push_back({4'd2, 8'h5C});
        write_frame(2'd1, 8'h82, 24'h5C0000, 1);
        check("after_partial_image", config_regs, 64'h07060504_A55C0133);

        // ena drop mid-read
        cs_low(2'd0);
        xfer(8'h08, 8, scratch);
        xfer(8'h00, 1, scratch);
        check("abort_first_bit", 64'(scratch), 64'h1);
        #HP;
        check("abort_miso_before", 64'(spi_miso), 64'h1);
        ena = 1'b0;
        #HP;
        check("abort_miso_after", 64'(spi_miso), 64'h0);
        spi_cs_n = 1'b1;
        #(2*HP);
        ena = 1'b1;
        $display("read  mode=0 cmd=08 aborted by ena");
        check("abort_image", config_regs, 64'h07060504_A55C0133);

        // Write to reg 5, then reset during a write
        exp_wr.push_back({4'd5, 8'h77});
        write_frame(2'd2, 8'h85, 24'h770000, 1);
        check("reg5_image", config_regs, 64'h07067704_A55C0133);
        cs_low(2'd0);
        xfer(8'h81, 8, scratch);
        xfer(8'hEE, 4, scratch);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("midrst_config", config_regs, RST_IMG);
        check("midrst_miso", 64'(spi_miso), 64'h0);
        check("midrst_stb", 64'(cfg_wr_stb), 64'h0);
        check("midrst_wr_addr", 64'(cfg_wr_addr), 64'h0);
        spi_cs_n = 1'b1;
        spi_clk  = mode[1];
        #HP;
        rst = 1'b0;
        #(2*HP);
        $display("write mode=0 cmd=81 interrupted by rst");

        read_frame(2'd0, 8'h10, 8'h00, 1'b0);
        read_frame(2'd1, 8'h04, 8'h04, 1'b0);
        write_frame(2'd0, 8'h8A, 24'h990000, 1);
        check("status_write_dropped", config_regs, RST_IMG);

        #(4*HP);
        check("pending_strobes", 64'(exp_wr.size()), 64'h0);
        check("pending_reads", 64'(exp_rd.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
